imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader upstream of the pipelined cpu.
- Receives the program as a byte stream over a valid/ready handshake and assembles bytes into WIDTH-bit instructions.
- Writes each instruction into instruction memory at consecutive addresses 0..INSTRACTION_NUMBERS-1.
- Holds the cpu in reset until the whole image is written, then releases it. A reload request re-enters loading at any time.

Parameters:
- WIDTH, 32: instruction width in bits; must be a multiple of 8. BYTES = WIDTH/8.
- INSTRACTION_NUMBERS, 8: number of instruction words loaded; ≥2. AW = $clog2(INSTRACTION_NUMBERS).
- RST_HOLD, 2: cycles cpu_rst stays high after the last memory write; ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  program byte; the first byte of each word is the MSB (big-endian).
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to restart loading from word 0.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  output  AW  word address of the write.
- imem_wdata  output  WIDTH  assembled instruction.
- cpu_rst  output  1  reset to the cpu, active-high.
- load_done  output  1  image loaded and cpu running.

Behaviour:
- Reset values (async, while rst=1): state=LOAD, byte_cnt=0, word_addr=0, hold_cnt=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_rst=1, load_done=0. in_ready=0 while rst=1.
- All outputs are registered except in_ready = (state==LOAD) && !reload && !rst.
- States:
  - LOAD: accept bytes.
  - WRITE: one cycle, memory write.
  - HOLD: reset-release delay.
  - RUN: cpu executing.
- LOAD:
  - A byte is accepted when in_valid && in_ready. The shift register takes {shift[WIDTH-9:0], in_data} and byte_cnt increments.
  - No acceptance → state unchanged; in_valid gaps are allowed anywhere.
  - When byte BYTES-1 is accepted in cycle t: in cycle t+1, state=WRITE, imem_we=1, imem_waddr=word_addr, imem_wdata=assembled word, byte_cnt=0.
- WRITE:
  - in_ready=0.
  - If word_addr==INSTRACTION_NUMBERS-1, next state is HOLD with hold_cnt=0. Otherwise word_addr+1 and back to LOAD.
  - imem_we falls to 0 at t+2.
- HOLD:
  - hold_cnt increments each cycle. When hold_cnt==RST_HOLD-1, next state is RUN with cpu_rst=0 and load_done=1.
  - cpu_rst therefore falls exactly RST_HOLD+1 cycles after the cycle in which the last imem_we=1.
- RUN:
  - in_ready=0; in_valid/in_data are ignored; all outputs are stable.
- reload (checked in every state, highest priority):
  - Next cycle: state=LOAD, byte_cnt=0, word_addr=0, hold_cnt=0, imem_we=0, cpu_rst=1, load_done=0.
  - Any partial word is discarded. A write scheduled in the same cycle (state WRITE) still completes, because imem_we is already registered.
  - reload and in_valid in the same cycle: no byte is accepted (in_ready=0).
- Wrap: word_addr never exceeds INSTRACTION_NUMBERS-1. Bytes arriving after the last word are not accepted.
- Async rst mid-load: immediate return to reset values, and loading restarts at word 0 after release.

Decomposition:
- Shared package (cpu_pkg): state encoding constants LOAD=2'd0, WRITE=2'd1, HOLD=2'd2, RUN=2'd3; constant BYTE_W=8.
- One sub-module, word_assembler: byte shift register plus byte counter, with inputs (clk, rst, clr, shift_en, in_data) and outputs (word, last_byte).
- FSM, address counter, hold counter and output registers live in imem_loader. The top-level cpu instantiates imem_loader and drives the cpu reset from cpu_rst.

Test Plan:
- Default params, stream 32 bytes 0x00..0x1F continuously → 8 imem_we pulses: addr0 = 0x00010203, addr7 = 0x1C1D1E1F. Each pulse is one cycle, 5 cycles apart (4 accept + 1 write).
- Same stream with in_valid toggled 1/0 every cycle → identical memory contents. in_ready=0 exactly in WRITE cycles and whenever rst=1.
- After last imem_we in cycle t → cpu_rst=1 through t+2, cpu_rst=0 and load_done=1 at t+3 (RST_HOLD=2). Later in_valid pulses in RUN → no imem_we, in_ready stays 0.
- reload after 3 words + 2 bytes → next write is addr 0 with the next four bytes, cpu_rst high from the following cycle. reload in RUN → cpu_rst=1, load_done=0 next cycle.
- Assert rst mid-word (byte 2 of word 4) → outputs reset immediately. After release, the full reload writes addr 0..7 correctly.
- reload and in_valid high in the same LOAD cycle → byte not consumed (in_ready=0). Byte_cnt=0 the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared types and constants for the boot-time program loader.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : word_assembler
// Purpose : Big-endian byte-to-word shifter with byte counter.
// Revision: 1.0 - initial release
// ============================================================================
module word_assembler
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] in_data,
  output logic [WIDTH-1:0]  word,
  output logic              last_byte
);

  localparam int BYTES = WIDTH / BYTE_W;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CW-1:0] r_byte_cnt;

  // word is the value including the byte on in_data, valid when last_byte fires
  assign last_byte = shift_en && (r_byte_cnt == CW'(BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
    end else if (clr || last_byte) begin
      r_byte_cnt <= '0;
    end else if (shift_en) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  generate
    if (BYTES > 1) begin : g_multi_byte
      logic [WIDTH-BYTE_W-1:0] r_shift;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_shift <= '0;
        end else if (shift_en) begin
          r_shift <= word[WIDTH-BYTE_W-1:0];
        end
      end

      assign word = {r_shift, in_data};
    end else begin : g_single_byte
      assign word = in_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Purpose : Streams a byte image into instruction memory, then releases cpu.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader
  import cpu_pkg::*;
#(
  parameter  int WIDTH               = 32,
  parameter  int INSTRACTION_NUMBERS = 8,
  parameter  int RST_HOLD            = 2,
  localparam int AW                  = $clog2(INSTRACTION_NUMBERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [AW-1:0]     imem_waddr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              cpu_rst,
  output logic              load_done
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t           r_state,      w_state_nxt;
  logic [AW-1:0]    r_word_addr,  w_word_addr_nxt;
  logic [HW-1:0]    r_hold_cnt,   w_hold_cnt_nxt;
  logic             w_we_nxt;
  logic [AW-1:0]    w_waddr_nxt;
  logic [WIDTH-1:0] w_wdata_nxt;
  logic             w_cpu_rst_nxt;
  logic             w_load_done_nxt;

  logic             w_accept;
  logic [WIDTH-1:0] w_word;
  logic             w_last_byte;

  assign in_ready = (r_state == LOAD) && !reload && !rst;
  assign w_accept = in_valid && in_ready;

  word_assembler #(
    .WIDTH (WIDTH)
  ) u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clr       (reload),
    .shift_en  (w_accept),
    .in_data   (in_data),
    .word      (w_word),
    .last_byte (w_last_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LOAD;
      r_word_addr <= '0;
      r_hold_cnt  <= '0;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      cpu_rst     <= 1'b1;
      load_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_addr <= w_word_addr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      imem_we     <= w_we_nxt;
      imem_waddr  <= w_waddr_nxt;
      imem_wdata  <= w_wdata_nxt;
      cpu_rst     <= w_cpu_rst_nxt;
      load_done   <= w_load_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_word_addr_nxt = r_word_addr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_we_nxt        = 1'b0;
    w_waddr_nxt     = imem_waddr;
    w_wdata_nxt     = imem_wdata;
    w_cpu_rst_nxt   = cpu_rst;
    w_load_done_nxt = load_done;

    // reload overrides every state; an in-flight write already sits in imem_we
    if (reload) begin
      w_state_nxt     = LOAD;
      w_word_addr_nxt = '0;
      w_hold_cnt_nxt  = '0;
      w_cpu_rst_nxt   = 1'b1;
      w_load_done_nxt = 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_last_byte) begin
            w_state_nxt = WRITE;
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_word_addr;
            w_wdata_nxt = w_word;
          end
        end
        WRITE: begin
          if (r_word_addr == AW'(INSTRACTION_NUMBERS - 1)) begin
            w_state_nxt    = HOLD;
            w_hold_cnt_nxt = '0;
          end else begin
            w_state_nxt     = LOAD;
            w_word_addr_nxt = r_word_addr + 1'b1;
          end
        end
        HOLD: begin
          if (r_hold_cnt == HW'(RST_HOLD - 1)) begin
            w_state_nxt     = RUN;
            w_cpu_rst_nxt   = 1'b0;
            w_load_done_nxt = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          end
        end
        RUN: begin
          w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Purpose : Randomized self-checking bench for imem_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int WIDTH    = 32;
  localparam int N        = 8;
  localparam int RST_HOLD = 2;
  localparam int AW       = 3;
  localparam int BYTES    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             reload;
  logic             imem_we;
  logic [AW-1:0]    imem_waddr;
  logic [WIDTH-1:0] imem_wdata;
  logic             cpu_rst;
  logic             load_done;

  imem_loader #(
    .WIDTH               (WIDTH),
    .INSTRACTION_NUMBERS (N),
    .RST_HOLD            (RST_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         addr;
    logic [31:0] data;
    int         cyc;
    logic       rdy;
  } wr_t;

  wr_t wq[$];
  wr_t mon_w;

  // every memory write the DUT issues, with the cycle it happened in
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      mon_w.addr = int'(imem_waddr);
      mon_w.data = imem_wdata;
      mon_w.cyc  = cyc;
      mon_w.rdy  = in_ready;
      wq.push_back(mon_w);
    end
  end

  int errors = 0;
  int checks = 0;

  // reference: word k of a big-endian byte image
  function automatic logic [31:0] word_at(input logic [7:0] b[$], input int k);
    return {b[BYTES*k], b[BYTES*k+1], b[BYTES*k+2], b[BYTES*k+3]};
  endfunction

  // mode 0: continuous, 1: toggle valid every byte, 2: random gaps
  task automatic send_bytes(input logic [7:0] b[$], input int mode);
    for (int i = 0; i < b.size(); i++) begin
      bit acc = 1'b0;
      int n   = 0;
      in_valid = 1'b1;
      in_data  = b[i];
      while (!acc && n < 50) begin
        #1;
        acc = in_ready;
        @(negedge clk);
        n++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d not accepted in %0d cycles", i, n);
      end
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k = 0;
    #1;
    while (wq.size() < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (wq.size() != n) begin
      errors++;
      $display("FAIL write_count: got %0d writes, want %0d", wq.size(), n);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (load_done !== 1'b1 && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL done: load_done=%b cpu_rst=%b, want 1/0", load_done, cpu_rst);
    end
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; reload = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (imem_we !== 1'b0 || imem_waddr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem: we=%b addr=%0d data=%h, want 0/0/0", imem_we, imem_waddr, imem_wdata);
    end
    checks++;
    if (cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_cpu: cpu_rst=%b load_done=%b, want 1/0", cpu_rst, load_done);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, want 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_continuous_load();
    logic [7:0] b[$];
    for (int i = 0; i < BYTES * N; i++) b.push_back(8'(i));
    wq.delete();
    send_bytes(b, 0);
    wait_writes(N);
    if (wq.size() == N) begin
      checks++;
      if (wq[0].data !== 32'h00010203 || wq[N-1].data !== 32'h1C1D1E1F) begin
        errors++;
        $display("FAIL cont_ends: w0=%h w7=%h, want 00010203/1c1d1e1f", wq[0].data, wq[N-1].data);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (wq[k].addr !== k || wq[k].data !== word_at(b, k) || wq[k].rdy !== 1'b0) begin
          errors++;
          $display("FAIL cont_word%0d: addr=%0d data=%h rdy=%b, want %0d/%h/0",
                   k, wq[k].addr, wq[k].data, wq[k].rdy, k, word_at(b, k));
        end
      end
      for (int k = 1; k < N; k++) begin
        checks++;
        if (wq[k].cyc - wq[k-1].cyc != BYTES + 1) begin
          errors++;
          $display("FAIL cont_spacing%0d: got %0d cycles, want %0d", k, wq[k].cyc - wq[k-1].cyc, BYTES + 1);
        end
      end
    end
  endtask

  task automatic test_release_and_run();
    int t;
    int g = 0;
    if (wq.size() == 0) return;
    t = wq[wq.size()-1].cyc;
    while (cyc <= t + RST_HOLD + 1 && g < 20) begin
      logic exp_rst;
      exp_rst = (cyc <= t + RST_HOLD);
      checks++;
      if (cpu_rst !== exp_rst || load_done !== !exp_rst) begin
        errors++;
        $display("FAIL release_c%0d: cpu_rst=%b load_done=%b, want %b/%b",
                 cyc - t, cpu_rst, load_done, exp_rst, !exp_rst);
      end
      @(negedge clk); #1;
      g++;
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL run_ready: in_ready=%b in RUN, want 0", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (wq.size() != N || imem_we !== 1'b0 || cpu_rst !== 1'b0 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL run_stable: writes=%0d we=%b cpu_rst=%b done=%b, want %0d/0/0/1",
               wq.size(), imem_we, cpu_rst, load_done, N);
    end
  endtask

  task automatic test_reload_in_run();
    pulse_reload();
    #1;
    checks++;
    if (cpu_rst !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_run: cpu_rst=%b done=%b in_ready=%b, want 1/0/1", cpu_rst, load_done, in_ready);
    end
  endtask

  task automatic test_gapped_load();
    logic [7:0] b[$];
    for (int i = 0; i < BYTES * N; i++) b.push_back(8'($urandom));
    wq.delete();
    send_bytes(b, 1);
    wait_writes(N);
    if (wq.size() == N) begin
      for (int k = 0; k < N; k++) begin
        checks++;
        if (wq[k].addr !== k || wq[k].data !== word_at(b, k) || wq[k].rdy !== 1'b0) begin
          errors++;
          $display("FAIL gap_word%0d: addr=%0d data=%h rdy=%b, want %0d/%h/0",
                   k, wq[k].addr, wq[k].data, wq[k].rdy, k, word_at(b, k));
        end
      end
    end
    wait_done();
  endtask

  task automatic test_reload_partial();
    logic [7:0] b1[$];
    logic [7:0] b2[$];
    pulse_reload();
    for (int i = 0; i < 3 * BYTES + 2; i++) b1.push_back(8'($urandom));
    for (int i = 0; i < BYTES * N; i++) b2.push_back(8'($urandom));
    wq.delete();
    send_bytes(b1, 0);
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_ready: in_ready=%b with reload, want 0", in_ready);
    end
    @(negedge clk);
    reload = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (cpu_rst !== 1'b1 || load_done !== 1'b0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL reload_after: cpu_rst=%b done=%b we=%b, want 1/0/0", cpu_rst, load_done, imem_we);
    end
    send_bytes(b2, 2);
    wait_writes(3 + N);
    if (wq.size() == 3 + N) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (wq[k].addr !== k || wq[k].data !== word_at(b1, k)) begin
          errors++;
          $display("FAIL partial_pre%0d: addr=%0d data=%h, want %0d/%h", k, wq[k].addr, wq[k].data, k, word_at(b1, k));
        end
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (wq[3+k].addr !== k || wq[3+k].data !== word_at(b2, k)) begin
          errors++;
          $display("FAIL partial_post%0d: addr=%0d data=%h, want %0d/%h",
                   k, wq[3+k].addr, wq[3+k].data, k, word_at(b2, k));
        end
      end
    end
    wait_done();
  endtask

  task automatic test_async_rst_mid_word();
    logic [7:0] b1[$];
    logic [7:0] b2[$];
    pulse_reload();
    for (int i = 0; i < 4 * BYTES + 2; i++) b1.push_back(8'(8'h41 + i));
    for (int i = 0; i < BYTES * N; i++) b2.push_back(8'($urandom));
    send_bytes(b1, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_we !== 1'b0 || imem_waddr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL arst_mem: we=%b addr=%0d data=%h, want 0/0/0", imem_we, imem_waddr, imem_wdata);
    end
    checks++;
    if (cpu_rst !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_ctl: cpu_rst=%b done=%b in_ready=%b, want 1/0/0", cpu_rst, load_done, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    send_bytes(b2, 2);
    wait_writes(N);
    if (wq.size() == N) begin
      for (int k = 0; k < N; k++) begin
        checks++;
        if (wq[k].addr !== k || wq[k].data !== word_at(b2, k)) begin
          errors++;
          $display("FAIL arst_word%0d: addr=%0d data=%h, want %0d/%h", k, wq[k].addr, wq[k].data, k, word_at(b2, k));
        end
      end
    end
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous_load();
    test_release_and_run();
    test_reload_in_run();
    test_gapped_load();
    test_reload_partial();
    test_async_rst_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
